// File: rtl/pipe_gen.sv
// pipe_gen: producer end of the pipe-field shift chain.
// Emits the 16-bit column that enters the rightmost column of the scrolling
// field. It alternates SPACING empty columns with PIPE_W wall columns. Each
// pipe carries a gap whose position is drawn from a 16-bit Galois LFSR.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   start        in   level; leaves IDLE when high (sampled only in IDLE)
//   shift_tick   in   one-cycle pulse; the field shifts and captures new_pipe
//   gameover     in   level; freezes all advancement while high
//   new_pipe     out  registered column for the next shift (1 = wall)
//   pipe_spawned out  one-cycle pulse when new_pipe becomes a pipe's first column
//   pipe_count   out  pipes spawned since reset, saturating at 255
//   busy         out  high in every state except IDLE
module pipe_gen #(
   parameter int          GAP_H   = 4,
   parameter int          PIPE_W  = 2,
   parameter int          SPACING = 5,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        shift_tick,
   input  logic        gameover,
   output logic [15:0] new_pipe,
   output logic        pipe_spawned,
   output logic [7:0]  pipe_count,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPACE = 2'd1,
      PIPE  = 2'd2
   } state_t;

   // The modulus keeps gap_top + GAP_H - 1 <= 14, so row 15 stays a wall.
   // The +1 offset keeps row 0 a wall.
   localparam logic [3:0]  GAP_MOD  = 4'(15 - GAP_H);
   localparam logic [15:0] GAP_MASK = 16'((32'd1 << GAP_H) - 32'd1);
   localparam logic [3:0]  SP_LAST  = 4'(SPACING - 1);
   localparam logic [3:0]  PW_LAST  = 4'(PIPE_W - 1);

   state_t      state_q, state_d;
   logic [3:0]  col_cnt_q, col_cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [3:0]  gap_top_q, gap_top_d;
   logic [15:0] new_pipe_q, new_pipe_d;
   logic        spawn_q, spawn_d;
   logic [7:0]  count_q, count_d;

   logic        acc;
   logic [15:0] lfsr_step;
   logic [3:0]  gap_new;

   function automatic logic [15:0] wall_col(input logic [3:0] top);
      return ~(GAP_MASK << top);
   endfunction

   assign acc       = shift_tick & ~gameover & (state_q != IDLE);
   assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   // The gap uses the pre-advance LFSR value on the edge that enters PIPE.
   assign gap_new   = 4'd1 + (lfsr_q[3:0] % GAP_MOD);

   always_comb begin
      state_d    = state_q;
      col_cnt_d  = col_cnt_q;
      lfsr_d     = lfsr_q;
      gap_top_d  = gap_top_q;
      new_pipe_d = new_pipe_q;
      spawn_d    = 1'b0;
      count_d    = count_q;

      if (acc) lfsr_d = lfsr_step;

      case (state_q)
         IDLE: begin
            new_pipe_d = 16'h0000;
            // gameover only masks ticks, so start still takes effect here.
            if (start) begin
               state_d   = SPACE;
               col_cnt_d = 4'd0;
            end
         end
         SPACE: begin
            if (acc) begin
               if (col_cnt_q == SP_LAST) begin
                  state_d    = PIPE;
                  gap_top_d  = gap_new;
                  new_pipe_d = wall_col(gap_new);
                  col_cnt_d  = 4'd0;
                  spawn_d    = 1'b1;
                  if (count_q != 8'hFF) count_d = count_q + 8'd1;
               end else begin
                  col_cnt_d = col_cnt_q + 4'd1;
               end
            end
         end
         PIPE: begin
            if (acc) begin
               if (col_cnt_q == PW_LAST) begin
                  state_d    = SPACE;
                  new_pipe_d = 16'h0000;
                  col_cnt_d  = 4'd0;
               end else begin
                  col_cnt_d  = col_cnt_q + 4'd1;
                  new_pipe_d = wall_col(gap_top_q);
               end
            end
         end
         default: begin
            state_d    = IDLE;
            new_pipe_d = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         col_cnt_q  <= 4'd0;
         lfsr_q     <= SEED;
         gap_top_q  <= 4'd1;
         new_pipe_q <= 16'h0000;
         spawn_q    <= 1'b0;
         count_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         col_cnt_q  <= col_cnt_d;
         lfsr_q     <= lfsr_d;
         gap_top_q  <= gap_top_d;
         new_pipe_q <= new_pipe_d;
         spawn_q    <= spawn_d;
         count_q    <= count_d;
      end
   end

   assign new_pipe     = new_pipe_q;
   assign pipe_spawned = spawn_q;
   assign pipe_count   = count_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pipe_gen.sv
module tb_pipe_gen;

   localparam int SPACING = 5;
   localparam int PIPE_W  = 2;

   logic        clk, reset, start, shift_tick, gameover;
   logic [15:0] new_pipe;
   logic        pipe_spawned;
   logic [7:0]  pipe_count;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [15:0] m_lfsr;

   pipe_gen dut (
      .clk(clk), .reset(reset), .start(start), .shift_tick(shift_tick),
      .gameover(gameover), .new_pipe(new_pipe), .pipe_spawned(pipe_spawned),
      .pipe_count(pipe_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        st, tk, go;
      logic [15:0] np;
      logic        sp;
      logic [7:0]  cnt;
      logic        bsy;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Reference wall for GAP_H = 4: gap_top = 1 + (lfsr[3:0] mod 11).
   function automatic logic [15:0] wall_of(input logic [15:0] l);
      int g;
      g = 1 + (int'(l[3:0]) % 11);
      return ~(16'h000F << g);
   endfunction

   function automatic int lowest_zero(input logic [15:0] v);
      for (int b = 0; b < 16; b++) if (!v[b]) return b;
      return 16;
   endfunction

   // One accepted tick; the model LFSR advances with it.
   task automatic do_tick();
      shift_tick = 1'b1;
      @(posedge clk); #1;
      shift_tick = 1'b0;
      m_lfsr = lfsr_nx(m_lfsr);
   endtask

   initial begin
      logic [15:0] pre, w;
      int g;

      vecs[0]  = '{"tick_no_start", 0,1,0, 16'h0000, 0, 8'd0, 0};
      vecs[1]  = '{"start",         1,0,0, 16'h0000, 0, 8'd0, 1};
      vecs[2]  = '{"t1",            0,1,0, 16'h0000, 0, 8'd0, 1};
      vecs[3]  = '{"t2",            0,1,0, 16'h0000, 0, 8'd0, 1};
      vecs[4]  = '{"t3",            0,1,0, 16'h0000, 0, 8'd0, 1};
      vecs[5]  = '{"t4",            0,1,0, 16'h0000, 0, 8'd0, 1};
      vecs[6]  = '{"t5_spawn",      0,1,0, 16'hFF0F, 1, 8'd1, 1};
      vecs[7]  = '{"no_tick_hold",  0,0,0, 16'hFF0F, 0, 8'd1, 1};
      vecs[8]  = '{"t6_wall2",      0,1,0, 16'hFF0F, 0, 8'd1, 1};
      vecs[9]  = '{"t7_space",      0,1,0, 16'h0000, 0, 8'd1, 1};
      vecs[10] = '{"t8",            0,1,0, 16'h0000, 0, 8'd1, 1};
      vecs[11] = '{"t9",            0,1,0, 16'h0000, 0, 8'd1, 1};
      vecs[12] = '{"t10",           0,1,0, 16'h0000, 0, 8'd1, 1};
      vecs[13] = '{"t11",           0,1,0, 16'h0000, 0, 8'd1, 1};
      // Pre-advance lfsr on t12 is AC58: 8 mod 11 = 8, gap_top 9 -> E1FF.
      vecs[14] = '{"t12_spawn2",    0,1,0, 16'hE1FF, 1, 8'd2, 1};

      reset = 1'b1; start = 1'b0; shift_tick = 1'b0; gameover = 1'b0;
      #3;
      chk("rst_new_pipe", new_pipe, 16'h0000);
      chk("rst_count", pipe_count, 8'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_spawn", pipe_spawned, 1'b0);
      #9 reset = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         start = vecs[i].st; shift_tick = vecs[i].tk; gameover = vecs[i].go;
         @(posedge clk); #1;
         chk({vecs[i].name, "_np"},   new_pipe,     vecs[i].np);
         chk({vecs[i].name, "_sp"},   pipe_spawned, vecs[i].sp);
         chk({vecs[i].name, "_cnt"},  pipe_count,   vecs[i].cnt);
         chk({vecs[i].name, "_busy"}, busy,         vecs[i].bsy);
      end
      start = 1'b0; shift_tick = 1'b0;

      m_lfsr = 16'hACE1;
      repeat (12) m_lfsr = lfsr_nx(m_lfsr);

      // Freeze while gameover is high, with ticks hammering every cycle.
      gameover = 1'b1; shift_tick = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("go_np", new_pipe, 16'hE1FF);
         chk("go_cnt", pipe_count, 8'd2);
         chk("go_sp", pipe_spawned, 1'b0);
      end
      gameover = 1'b0; shift_tick = 1'b0;
      do_tick();
      chk("resume_wall2", new_pipe, 16'hE1FF);
      do_tick();
      chk("resume_space", new_pipe, 16'h0000);
      repeat (SPACING - 1) do_tick();
      chk("resume_space_end", new_pipe, 16'h0000);
      pre = m_lfsr;
      do_tick();
      chk("pipe3_np", new_pipe, wall_of(pre));
      chk("pipe3_sp", pipe_spawned, 1'b1);
      chk("pipe3_cnt", pipe_count, 8'd3);

      // Asynchronous reset between edges, mid-PIPE.
      #3 reset = 1'b1;
      #1;
      chk("amid_np", new_pipe, 16'h0000);
      chk("amid_busy", busy, 1'b0);
      chk("amid_cnt", pipe_count, 8'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // start with gameover high still leaves IDLE.
      start = 1'b1; gameover = 1'b1;
      @(posedge clk); #1;
      chk("start_go_busy", busy, 1'b1);
      start = 1'b0; gameover = 1'b0;

      // 300 pipes from seed: gap model, wall rows, saturation.
      m_lfsr = 16'hACE1;
      for (int i = 0; i < 300; i++) begin
         repeat (SPACING - 1) do_tick();
         chk("run_space", new_pipe, 16'h0000);
         pre = m_lfsr;
         do_tick();
         w = new_pipe;
         if (i == 0) chk("restart_first", w, 16'hFF0F);
         chk("run_wall", w, wall_of(pre));
         chk("run_sp", pipe_spawned, 1'b1);
         chk("run_row0", w[0], 1'b1);
         chk("run_row15", w[15], 1'b1);
         g = lowest_zero(w);
         chk("run_gap_range", (g >= 1 && g <= 11), 1'b1);
         chk("run_cnt", pipe_count, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
         for (int k = 1; k < PIPE_W; k++) begin
            do_tick();
            chk("run_wall_hold", new_pipe, w);
         end
         do_tick();
         chk("run_back_space", new_pipe, 16'h0000);
         chk("run_sp_low", pipe_spawned, 1'b0);
      end
      chk("sat_final", pipe_count, 8'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
